// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NUM_REQ
// valid/ready requesters, with a bounded lock for back-to-back bursts.
module reg_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int NUM_REGS   = 8,
  parameter  int ELEM_WIDTH = 32,
  parameter  int MAX_LOCK   = 4,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_REQ*ELEM_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [NUM_REGS-1:0]          wr_en_o,
  output logic [ELEM_WIDTH-1:0]        wr_data_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic                         err_o,
  output logic                         locked_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [ADDR_W:0]    REGS_LIM = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [PTR_W-1:0]   LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   LOCK_LIM = CNT_W'(MAX_LOCK);
  localparam bit                 LOCK_EN  = (MAX_LOCK > 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              found;
  logic              hs;
  logic              hs_lock;
  logic [ADDR_W-1:0] hs_addr;
  logic [ELEM_WIDTH-1:0] hs_data;

  // Grant selection: in LOCKED only the owner is eligible, otherwise the first
  // valid requester at or after rr_ptr wins.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default up front so no path
    // leaves it unassigned, which would otherwise infer a latch.
    idx         = 0;
    found       = 1'b0;
    grant_idx   = owner;
    req_ready_o = '0;
    if (state == ST_LOCKED) begin
      found = req_valid_i[owner];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(rr_ptr) + i) % NUM_REQ;
        if (!found && req_valid_i[idx]) begin
          found     = 1'b1;
          grant_idx = PTR_W'(idx);
        end
      end
    end
    if (found && !rst_i) req_ready_o[grant_idx] = 1'b1;
  end

  assign hs = |req_ready_o;

  always_comb begin
    hs_addr = '0;
    hs_data = '0;
    hs_lock = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == grant_idx) begin
        hs_addr = req_addr_i[k*ADDR_W +: ADDR_W];
        hs_data = req_data_i[k*ELEM_WIDTH +: ELEM_WIDTH];
        hs_lock = req_lock_i[k];
      end
    end
  end

  assign next_ptr = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
  assign cnt_next = lock_cnt + 1'b1;
  assign locked_o = (state == ST_LOCKED);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      wr_en_o   <= '0;
      wr_data_o <= '0;
      wr_addr_o <= '0;
      err_o     <= 1'b0;
    end else begin
      wr_en_o <= '0;
      err_o   <= 1'b0;
      if (hs) begin
        wr_addr_o <= hs_addr;
        if ({1'b0, hs_addr} < REGS_LIM) begin
          wr_en_o   <= {{(NUM_REGS-1){1'b0}}, 1'b1} << hs_addr;
          wr_data_o <= hs_data;
        end else begin
          err_o <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (hs) begin
            if (hs_lock && LOCK_EN) begin
              state    <= ST_LOCKED;
              owner    <= grant_idx;
              lock_cnt <= CNT_W'(1);
            end else begin
              rr_ptr <= next_ptr;
            end
          end
        end
        ST_LOCKED: begin
          // Owner dropping valid, dropping lock, or hitting the cap all release.
          if (!hs || !hs_lock || cnt_next == LOCK_LIM) begin
            state    <= ST_IDLE;
            rr_ptr   <= next_ptr;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= cnt_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: reset, round-robin, lock burst, early
// release, out-of-range address and reset during a lock.
module tb_reg_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 6;
  localparam int EW    = 32;
  localparam int ML    = 4;
  localparam int AW    = $clog2(NREGS);

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_lock  = '0;
  logic [AW-1:0]       addr [NREQ];
  logic [EW-1:0]       data [NREQ];
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*EW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [NREGS-1:0]    wr_en;
  logic [EW-1:0]       wr_data;
  logic [AW-1:0]       wr_addr;
  logic                err;
  logic                locked;
  logic [EW-1:0]       bank [NREGS];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = addr[g];
    assign req_data[g*EW +: EW] = data[g];
  end

  reg_wr_arbiter #(
    .NUM_REQ(NREQ), .NUM_REGS(NREGS), .ELEM_WIDTH(EW), .MAX_LOCK(ML)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_lock_i(req_lock),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready), .wr_en_o(wr_en), .wr_data_o(wr_data),
    .wr_addr_o(wr_addr), .err_o(err), .locked_o(locked)
  );

  always #5 clk_i = ~clk_i;

  // Register bank model fed by the arbiter's write port.
  always @(posedge clk_i) begin
    for (int k = 0; k < NREGS; k++) begin
      if (rst_i) bank[k] <= '0;
      else if (wr_en[k]) bank[k] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      addr[k] = AW'(k);
      data[k] = 32'hA0 + 32'(k);
    end

    // Reset with everyone requesting
    req_valid = 4'hF;
    tick();
    tick();
    check("rst_ready",  32'(req_ready), 32'h0);
    check("rst_wr_en",  32'(wr_en),     32'h0);
    check("rst_data",   wr_data,        32'h0);
    check("rst_err",    32'(err),       32'h0);
    check("rst_locked", 32'(locked),    32'h0);

    // Round-robin: grants 0,1,2,3,0
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rr_ready%0d", i), 32'(req_ready), 32'h1 << (i % 4));
      tick();
      check($sformatf("rr_wr_en%0d", i), 32'(wr_en), 32'h1 << (i % 4));
      check($sformatf("rr_data%0d", i),  wr_data,    32'hA0 + 32'(i % 4));
      check($sformatf("rr_addr%0d", i),  32'(wr_addr), 32'(i % 4));
    end
    req_valid = '0;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    tick();
    check("idle_wr_en", 32'(wr_en), 32'h0);
    check("idle_hold",  wr_data,    32'hA0);
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_bank%0d", k), bank[k], 32'hA0 + 32'(k));

    // Move rr_ptr to 2 via a single write from requester 1
    req_valid = 4'b0010;
    addr[1] = 3'd4;
    data[1] = 32'h11;
    #1;
    check("pre_ready", 32'(req_ready), 32'h2);
    tick();
    check("pre_wr_en", 32'(wr_en), 32'h10);

    // Lock burst from requester 2, capped at 4 grants
    req_valid = 4'hF;
    req_lock  = 4'b0100;
    addr[2]   = 3'd5;
    for (int n = 0; n < 4; n++) begin
      data[2] = 32'hB0 + 32'(n);
      #1;
      check($sformatf("lk_ready%0d", n), 32'(req_ready), 32'h4);
      tick();
      check($sformatf("lk_locked%0d", n), 32'(locked), (n < 3) ? 32'h1 : 32'h0);
      check($sformatf("lk_wr_en%0d", n),  32'(wr_en),  32'h20);
      check($sformatf("lk_data%0d", n),   wr_data,     32'hB0 + 32'(n));
    end
    #1;
    check("lk_next_ready", 32'(req_ready), 32'h8);
    req_valid = '0;
    req_lock  = '0;
    tick();
    check("lk_gap_wr_en", 32'(wr_en), 32'h0);

    // Early release: requester 1 locks then drops valid
    req_valid = 4'b0110;
    req_lock  = 4'b0010;
    addr[1]   = 3'd1;
    data[1]   = 32'hC1;
    #1;
    check("er_ready", 32'(req_ready), 32'h2);
    tick();
    check("er_locked", 32'(locked), 32'h1);
    check("er_wr_en",  32'(wr_en),  32'h02);
    check("er_data",   wr_data,     32'hC1);
    req_valid = 4'b0100;
    #1;
    check("er_stall_ready", 32'(req_ready), 32'h0);
    tick();
    check("er_unlocked", 32'(locked), 32'h0);
    check("er_no_write", 32'(wr_en),  32'h0);
    #1;
    check("er_next_ready", 32'(req_ready), 32'h4);
    req_valid = '0;
    req_lock  = '0;
    tick();

    // Out-of-range address from requester 0
    req_valid = 4'b0001;
    addr[0]   = 3'd7;
    data[0]   = 32'hDEAD;
    #1;
    check("bad_ready", 32'(req_ready), 32'h1);
    tick();
    check("bad_wr_en", 32'(wr_en),   32'h0);
    check("bad_err",   32'(err),     32'h1);
    check("bad_addr",  32'(wr_addr), 32'h7);
    req_valid = '0;
    tick();
    check("bad_err_clr", 32'(err), 32'h0);
    check("bank0", bank[0], 32'hA0);
    check("bank1", bank[1], 32'hC1);
    check("bank2", bank[2], 32'hA2);
    check("bank3", bank[3], 32'hA3);
    check("bank4", bank[4], 32'h11);
    check("bank5", bank[5], 32'hB3);

    // Reset while requester 0 holds a lock
    req_valid = 4'b0001;
    req_lock  = 4'b0001;
    addr[0]   = 3'd0;
    data[0]   = 32'hE0;
    #1;
    check("rl_ready", 32'(req_ready), 32'h1);
    tick();
    check("rl_locked", 32'(locked), 32'h1);
    check("rl_wr_en",  32'(wr_en),  32'h01);
    rst_i = 1'b1;
    #1;
    check("rl_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("rl_unlocked", 32'(locked), 32'h0);
    check("rl_wr_en0",   32'(wr_en),  32'h0);
    check("rl_data0",    wr_data,     32'h0);
    rst_i     = 1'b0;
    req_valid = 4'hF;
    req_lock  = '0;
    #1;
    check("rl_rr_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Round-robin write-port arbiter for a bank of NUM_REGS `register` instances (each with ELEM_WIDTH data and a per-register enable).
- Shares that single write path between NUM_REQ requesters using valid/ready handshakes.
- Supports a bounded lock for back-to-back bursts from one requester.
- Drives the bank's per-register enables and a common data bus, registered, so the bank sees one write per cycle at most.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 8, number of registers in the bank (2..32, need not be a power of 2)
- ELEM_WIDTH, 32, data width per register
- ADDR_W, $clog2(NUM_REGS), register address width (derived localparam)
- MAX_LOCK, 4, maximum handshakes granted to one owner per lock (>=1)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester write request
- req_lock_i  in  NUM_REQ  requester wants to keep the grant after this transfer
- req_addr_i  in  NUM_REQ*ADDR_W  flattened addresses; requester k at [k*ADDR_W +: ADDR_W]
- req_data_i  in  NUM_REQ*ELEM_WIDTH  flattened write data; requester k at [k*ELEM_WIDTH +: ELEM_WIDTH]
- req_ready_o  out  NUM_REQ  one-hot-or-zero grant; a transfer occurs when valid&ready
- wr_en_o  out  NUM_REGS  one-hot-or-zero enable to the bank (en_i of each register)
- wr_data_o  out  ELEM_WIDTH  common write data (d_i of every register)
- wr_addr_o  out  ADDR_W  address of the current write, for debug/trace
- err_o  out  1  one-cycle pulse: accepted write had addr >= NUM_REGS
- locked_o  out  1  high while in LOCKED state

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, rr_ptr=0, owner=0, lock_cnt=0, wr_en_o=0, wr_data_o=0, wr_addr_o=0, err_o=0. req_ready_o is forced to 0 while rst_i=1. Reset overrides every other event, including a lock in progress.
- req_ready_o is combinational from req_valid_i, state, rr_ptr and owner; it never asserts for a requester whose valid is low.
- IDLE: winner = first k with req_valid_i[k]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ. req_ready_o[winner]=1. No valid -> all ready 0, state unchanged.
- On a handshake by winner g in IDLE:
  - If req_lock_i[g]=1 and MAX_LOCK>1: go to LOCKED, owner=g, lock_cnt=1.
  - Otherwise stay in IDLE with rr_ptr=(g+1) mod NUM_REQ.
- LOCKED:
  - Only owner may receive ready (req_ready_o[owner]=req_valid_i[owner]); other requesters stall.
  - An owner handshake increments lock_cnt.
  - Exit to IDLE, with rr_ptr=(owner+1) mod NUM_REQ, when any of these holds:
    - owner handshakes with req_lock_i[owner]=0
    - owner handshakes and lock_cnt reaches MAX_LOCK (forced release even if lock is still high)
    - req_valid_i[owner]=0 in any LOCKED cycle (release with no transfer that cycle)
  - On exit, lock_cnt=0.
- Write output, one cycle latency. The cycle after a handshake with address a and data d:
  - If a<NUM_REGS: wr_en_o has exactly bit a set, wr_data_o=d, wr_addr_o=a.
  - If a>=NUM_REGS: wr_en_o=0, err_o=1, wr_addr_o=a. The transfer still counts as accepted, for both the lock count and the rr_ptr update.
  - No handshake in a cycle -> wr_en_o=0 and err_o=0 the next cycle. wr_data_o and wr_addr_o hold their previous values.
- Full throughput: one accepted write per cycle is sustained in both IDLE and LOCKED.
- Fairness: with all requesters continuously valid and lock low, each is granted once every NUM_REQ cycles.
- Simultaneous events: a valid drop on another requester has no effect in LOCKED. A lock request on the same cycle as a forced release is ignored; that requester re-arbitrates normally.

Test Plan:
- Reset: drive rst_i=1 for 2 cycles with all 4 requesters valid -> req_ready_o=0, wr_en_o=0, wr_data_o=0, err_o=0. First cycle after release grants requester 0.
- Round-robin: all 4 valid, lock=0, req k writes addr k with data 32'hA0+k -> grants 0,1,2,3,0; wr_en_o goes 8'h01,8'h02,8'h04,8'h08 one cycle after each grant; the bank contents match.
- Lock burst: req 2 lock=1 with MAX_LOCK=4, req 0/1/3 valid -> req 2 gets 4 consecutive grants, locked_o high, then a forced release; next grant goes to req 3.
- Early release: req 1 locks, then drops valid for a cycle -> locked_o falls, no write that cycle, next grant goes to req 2.
- Bad address: NUM_REGS=6, req 0 writes addr 7 -> req_ready_o[0]=1; next cycle wr_en_o=0, err_o=1, wr_addr_o=7; the bank is unchanged.
- Reset mid-lock: assert rst_i during the LOCKED state -> next cycle state=IDLE, locked_o=0, rr_ptr=0, and no write is issued.
